// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Pipeline hazard controller for the 5-stage core. Resolves RAW hazards by
// forwarding into the execute stage, stalls decode on a load-use dependency,
// flushes on a taken branch, and freezes the pipe while a multi-cycle load
// completes in the memory stage.
//
// Optional feature macro: HAZARD_STATS_EN
//   defined   -> stall_count / flush_count count cycles with stalld / flushe
//                high (saturating, cleared by reset)
//   undefined -> counters are not built, both outputs tie to 0
//
// Parameters
//   LOAD_LAT  data-memory load latency in cycles (1..16), 1 = no wait
//   CNT_W     width of the statistics counters
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   rs1d, rs2d            decode-stage source tags
//   rs1e, rs2e, rde       execute-stage source / destination tags
//   resultsrce0           execute-stage instruction is a load
//   pcsrce                taken branch/jump resolved in execute
//   rdm, regwritem        memory-stage destination tag and write enable
//   memreadm              valid load occupying the memory stage
//   rdw, regwritew        writeback-stage destination tag and write enable
//   forwardae/forwardbe   operand selects: 00 regfile, 10 mem ALU, 01 wb
//   stallf..flushw        pipeline register stall / clear controls
//   stall_count           cycles with stalld=1
//   flush_count           cycles with flushe=1
// -----------------------------------------------------------------------------
module hazard_unit #(
   parameter int LOAD_LAT = 2,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs1d,
   input  logic [4:0]       rs2d,
   input  logic [4:0]       rs1e,
   input  logic [4:0]       rs2e,
   input  logic [4:0]       rde,
   input  logic             resultsrce0,
   input  logic             pcsrce,
   input  logic [4:0]       rdm,
   input  logic             regwritem,
   input  logic             memreadm,
   input  logic [4:0]       rdw,
   input  logic             regwritew,
   output logic [1:0]       forwardae,
   output logic [1:0]       forwardbe,
   output logic             stallf,
   output logic             stalld,
   output logic             flushd,
   output logic             flushe,
   output logic             stalle,
   output logic             stallm,
   output logic             flushw,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   // A load needing LOAD_LAT cycles stalls for LOAD_LAT-1 of them; the first
   // stall cycle is spent in IDLE, so the wait counter starts at LOAD_LAT-2.
   localparam bit         WAIT_EN  = (LOAD_LAT > 1);
   localparam logic [3:0] CNT_INIT = WAIT_EN ? 4'(LOAD_LAT - 2) : 4'd0;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       memstall;
   logic       lwstall;
   logic [1:0] fwd_a, fwd_b;

   // Memory-stage match wins over writeback: it holds the younger value.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rd_m,
                                          input logic       we_m,
                                          input logic [4:0] rd_w,
                                          input logic       we_w);
      logic [1:0] sel;
      sel = 2'b00;
      if (rs != 5'd0 && we_m && rd_m == rs)
         sel = 2'b10;
      else if (rs != 5'd0 && we_w && rd_w == rs)
         sel = 2'b01;
      return sel;
   endfunction

   always_comb begin
      fwd_a = fwd_sel(rs1e, rdm, regwritem, rdw, regwritew);
      fwd_b = fwd_sel(rs2e, rdm, regwritem, rdw, regwritew);
   end

   assign lwstall = resultsrce0 && (rde != 5'd0) && (rde == rs1d || rde == rs2d);

   // Memory-wait FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // WAIT ignores memreadm: the stalled load is still sitting in the stage.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      memstall = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (memreadm && WAIT_EN) begin
               memstall = 1'b1;
               state_d  = S_WAIT;
               cnt_d    = CNT_INIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               memstall = 1'b1;
               cnt_d    = cnt_q - 4'd1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Outputs are gated by reset directly so asserting reset clears them
   // without waiting for a clock edge.
   always_comb begin
      forwardae = 2'b00;
      forwardbe = 2'b00;
      stallf    = 1'b0;
      stalld    = 1'b0;
      flushd    = 1'b0;
      flushe    = 1'b0;
      stalle    = 1'b0;
      stallm    = 1'b0;
      flushw    = 1'b0;
      if (reset) begin
         forwardae = fwd_a;
         forwardbe = fwd_b;
         if (memstall) begin
            // Whole front of the pipe freezes; branch and load-use are
            // re-evaluated after the wait because execute is held.
            stallf = 1'b1;
            stalld = 1'b1;
            stalle = 1'b1;
            stallm = 1'b1;
            flushw = 1'b1;
         end else begin
            stallf = lwstall;
            stalld = lwstall;
            flushd = pcsrce;
            flushe = lwstall | pcsrce;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stalld && stall_cnt_q != {CNT_W{1'b1}})
         stall_cnt_d = stall_cnt_q + 1'b1;
      if (flushe && flush_cnt_q != {CNT_W{1'b1}})
         flush_cnt_d = flush_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;
`else
   assign stall_count = '0;
   assign flush_count = '0;
`endif

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control block for the 5-stage core. It consumes the register tags that the decode/execute pipeline register presents on its execute side (rs1e, rs2e, rde), plus the decode, memory and writeback tags.
- It drives the stall and clear inputs of the fetch/decode, decode/execute, execute/memory and memory/writeback registers, and the execute-stage operand forwarding selects.
- It contains a sequential wait FSM that holds a load in the memory stage when data memory needs more than one cycle.

Parameters:
- LOAD_LAT, 2, data-memory load latency in cycles (legal 1..16); 1 means no memory wait.
- CNT_W, 32, width of the optional statistics counters.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- rs1d  input  5  decode-stage source register 1
- rs2d  input  5  decode-stage source register 2
- rs1e  input  5  execute-stage source register 1
- rs2e  input  5  execute-stage source register 2
- rde  input  5  execute-stage destination register
- resultsrce0  input  1  execute-stage instruction is a load
- pcsrce  input  1  taken branch/jump resolved in execute
- rdm  input  5  memory-stage destination register
- regwritem  input  1  memory-stage instruction writes the register file
- memreadm  input  1  valid load occupying the memory stage
- rdw  input  5  writeback-stage destination register
- regwritew  input  1  writeback-stage instruction writes the register file
- forwardae  output  2  operand A select: 00 register file, 10 memory-stage ALU result, 01 writeback result
- forwardbe  output  2  operand B select, same encoding as forwardae
- stallf  output  1  hold the PC
- stalld  output  1  hold the fetch/decode register
- flushd  output  1  clear the fetch/decode register
- flushe  output  1  clear the decode/execute register
- stalle  output  1  hold the decode/execute register
- stallm  output  1  hold the execute/memory register
- flushw  output  1  insert a bubble into the memory/writeback register
- stall_count  output  CNT_W  cycles with stalld=1 (optional feature)
- flush_count  output  CNT_W  cycles with flushe=1 (optional feature)

Behaviour:
- Reset is asynchronous, active-low; clk is the only clock.
  - While reset=0: FSM=IDLE, cnt=0, counters=0.
  - While reset=0, all stall and flush outputs are 0 and forwardae/forwardbe are 00, regardless of the inputs.
- Forwarding is purely combinational, 0 cycles of latency, and is active in every state.
  - forwardae=10 if rs1e!=0 && regwritem && rdm==rs1e.
  - Otherwise forwardae=01 if rs1e!=0 && regwritew && rdw==rs1e.
  - Otherwise forwardae=00.
  - The memory-stage match has priority over the writeback-stage match.
  - forwardbe uses the same rules with rs2e.
- Load-use hazard: lwstall = resultsrce0 && rde!=0 && (rde==rs1d || rde==rs2d).
- Memory-wait FSM uses states IDLE and WAIT with a 4-bit counter cnt.
  - IDLE: if memreadm && LOAD_LAT>1, then memstall=1, next state WAIT, cnt<=LOAD_LAT-2. Otherwise memstall=0.
  - WAIT with cnt!=0: memstall=1, cnt<=cnt-1.
  - WAIT with cnt==0: memstall=0, next state IDLE (the load advances on this edge).
  - Net effect: a load stays in the memory stage for exactly LOAD_LAT cycles, and memstall is high for LOAD_LAT-1 cycles.
  - LOAD_LAT=1: the FSM never leaves IDLE.
  - Back-to-back loads: the next load enters the memory stage in IDLE and retriggers the FSM with no gap cycle.
- Output equations when memstall=1 (memory wait has priority):
  - stallf=stalld=stalle=stallm=flushw=1.
  - flushd=flushe=0.
  - lwstall and pcsrce are ignored; the execute stage is frozen, so both are re-evaluated once memstall drops.
- Output equations when memstall=0:
  - stallf=stalld=lwstall.
  - flushd=pcsrce.
  - flushe=lwstall|pcsrce.
  - stalle=stallm=flushw=0.
- lwstall and pcsrce may be high together: flushe=1, flushd=1, stallf=stalld=1.
- Reset asserted mid-WAIT aborts the wait immediately. After release the FSM is in IDLE and re-evaluates memreadm on the next edge.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - stall_count increments on each clock edge where stalld=1.
  - flush_count increments on each clock edge where flushe=1.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: the counter registers are not built, and stall_count and flush_count are tied to 0.

Test Plan:
- Forwarding: rs1e=5, rdm=5, regwritem=1, rdw=5, regwritew=1 -> forwardae=10. Set regwritem=0 -> forwardae=01. Set rs1e=0 -> forwardae=00.
- Load-use: resultsrce0=1, rde=7, rs2d=7 -> stallf=stalld=flushe=1, flushd=0. Set rde=0 -> all four outputs 0.
- Branch: pcsrce=1, no load in execute -> flushd=flushe=1, stallf=stalld=0. With lwstall also active -> flushd=flushe=stallf=stalld=1.
- Memory wait, LOAD_LAT=3: memreadm=1 from cycle t -> stallf/stalld/stalle/stallm/flushw=1 in cycles t and t+1, 0 in cycle t+2. A new load at t+3 gives stalls in t+3 and t+4. Concurrent pcsrce=1 during t -> flushd=0.
- Reset mid-wait, LOAD_LAT=4: drive reset=0 at t+1 -> all stall/flush outputs 0 without waiting for a clock edge. Release reset with memreadm=0 -> no stall. Then memreadm=1 -> 3 stall cycles.
- Statistics with HAZARD_STATS_EN defined: 3 load-use cycles plus 2 separate pcsrce cycles -> stall_count=3, flush_count=5. Without the macro, both outputs read 0.
